// File: rtl/spi_pkg.sv
// Shared types and constants for the streaming SPI master.
// Mode encoding is {cpol, cpha}.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_WAIT  = 3'd3,
        ST_TRAIL = 3'd4
    } spi_state_e;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCK divider: down-counter with terminal-count tick, plus lead/trail edge strobes.
// clr reloads the count and restarts at a leading edge.
module spi_clk_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic             edge_en,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             lead_edge,
    output logic             trail_edge
);

    logic [DIV_W-1:0] cnt;
    logic             phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clr) begin
            cnt   <= div;
            phase <= 1'b0;
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= div;
                if (edge_en) begin
                    phase <= ~phase;
                end
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

    assign tick       = run && !clr && (cnt == '0);
    assign lead_edge  = tick && edge_en && !phase;
    assign trail_edge = tick && edge_en && phase;

endmodule

// File: rtl/spi_master_stream.sv
// Streaming SPI master: one chip-select window per transaction, back-to-back words,
// configurable CPOL/CPHA and SCK divider, config latched at transaction start.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | cs_n all high, sck follows cfg_cpol, tx_ready high
// LEAD     | cs_n asserted, setup time of one half-period before first edge
// SHIFT    | sck toggling, 2*DATA_W edges per word
// WAIT     | between words of one transaction, sck idle, cs_n held
// TRAIL    | hold time of one half-period after the last word
module spi_master_stream
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_cpol,
    input  logic                         cfg_cpha,
    input  logic [DIV_W-1:0]             cfg_div,
    input  logic [sel_width(NUM_CS)-1:0] cfg_cs_sel,
    input  logic                         tx_valid,
    input  logic [DATA_W-1:0]            tx_data,
    input  logic                         tx_last,
    output logic                         tx_ready,
    output logic                         rx_valid,
    output logic [DATA_W-1:0]            rx_data,
    output logic                         busy,
    output logic                         sck,
    output logic                         mosi,
    input  logic                         miso,
    output logic [NUM_CS-1:0]            cs_n
);

    localparam int                SEL_W     = sel_width(NUM_CS);
    localparam int                ECNT_W    = $clog2(2 * DATA_W);
    localparam logic [ECNT_W-1:0] EDGE_LAST = ECNT_W'(2 * DATA_W - 1);
    localparam logic [ECNT_W-1:0] EDGE_PEN  = ECNT_W'(2 * DATA_W - 2);

    spi_state_e        state, state_nxt;
    logic              run_q;
    logic              load_word, cap_cfg;
    logic              sel_ok;

    logic              cpol_r, cpha_r, last_r;
    logic [DIV_W-1:0]  div_r;
    logic [SEL_W-1:0]  sel_r;

    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic [ECNT_W-1:0] edge_cnt;

    logic              tick, lead_edge, trail_edge;
    logic              sample_now, shift_now, word_done, cpha_ld;
    logic [DIV_W-1:0]  div_in;

    logic              miso_s1, miso_s2;
    logic [1:0]        smp_d, smpl_d;

    assign sel_ok     = (32'(cfg_cs_sel) < 32'(NUM_CS));
    assign sample_now = cpha_r ? trail_edge : lead_edge;
    assign shift_now  = cpha_r ? lead_edge : trail_edge;
    assign word_done  = trail_edge && (edge_cnt == EDGE_LAST);
    assign cpha_ld    = (state == ST_IDLE) ? cfg_cpha : cpha_r;
    assign div_in     = (state == ST_IDLE) ? cfg_div : div_r;
    assign busy       = (state != ST_IDLE);

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        ((state == ST_IDLE) || (state == ST_WAIT)),
        .run        ((state == ST_LEAD) || (state == ST_SHIFT) || (state == ST_TRAIL)),
        .edge_en    (state == ST_SHIFT),
        .div        (div_in),
        .tick       (tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            run_q <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        tx_ready  = 1'b0;
        load_word = 1'b0;
        cap_cfg   = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_ready = run_q;
                // Out-of-range selects are consumed without starting a transaction.
                if (run_q && tx_valid && sel_ok) begin
                    load_word = 1'b1;
                    cap_cfg   = 1'b1;
                    state_nxt = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (word_done) begin
                    if (last_r) begin
                        state_nxt = ST_TRAIL;
                    end else begin
                        tx_ready = 1'b1;
                        if (tx_valid) begin
                            load_word = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    load_word = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpol_r <= 1'b0;
            cpha_r <= 1'b0;
            div_r  <= '0;
            sel_r  <= '0;
        end else if (cap_cfg) begin
            cpol_r <= cfg_cpol;
            cpha_r <= cfg_cpha;
            div_r  <= cfg_div;
            sel_r  <= cfg_cs_sel;
        end
    end

    // CPHA=0 presents the MSB at load time; CPHA=1 shifts it out on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sh    <= '0;
            mosi     <= 1'b0;
            last_r   <= 1'b0;
            edge_cnt <= '0;
        end else if (load_word) begin
            last_r   <= tx_last;
            edge_cnt <= '0;
            if (cpha_ld) begin
                tx_sh <= tx_data;
            end else begin
                tx_sh <= {tx_data[DATA_W-2:0], 1'b0};
                mosi  <= tx_data[DATA_W-1];
            end
        end else begin
            if (lead_edge || trail_edge) begin
                edge_cnt <= word_done ? '0 : edge_cnt + ECNT_W'(1);
            end
            if (shift_now && !word_done) begin
                mosi  <= tx_sh[DATA_W-1];
                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck <= 1'b0;
        end else if (state == ST_IDLE) begin
            sck <= cfg_cpol;
        end else if (state == ST_SHIFT) begin
            if (lead_edge || trail_edge) begin
                sck <= ~sck;
            end
        end else begin
            sck <= cpol_r;
        end
    end

    // Samples are taken two clocks after the SCK edge so the capture sees the
    // synchroniser output for the miso level present at that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_s1  <= 1'b0;
            miso_s2  <= 1'b0;
            smp_d    <= '0;
            smpl_d   <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            miso_s1  <= miso;
            miso_s2  <= miso_s1;
            smp_d    <= {smp_d[0], sample_now};
            smpl_d   <= {smpl_d[0], sample_now && (edge_cnt >= EDGE_PEN)};
            rx_valid <= 1'b0;
            if (smp_d[1]) begin
                rx_sh <= {rx_sh[DATA_W-2:0], miso_s2};
                if (smpl_d[1]) begin
                    rx_data  <= {rx_sh[DATA_W-2:0], miso_s2};
                    rx_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (busy && (sel_r == SEL_W'(i))) begin
                cs_n[i] = 1'b0;
            end
        end
    end

endmodule
